// File: rtl/issue_scheduler_pkg.sv
// Shared types, opcode constants and decode helpers for the issue scheduler.
package issue_scheduler_pkg;

  localparam int RS_PER_FU = 2;
  localparam int FU_CNT    = 3;
  localparam int NUM_REGS  = 32;
  localparam int REG_W     = 5;
  localparam int TAG_W     = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BU  = 2'd1,
    FU_LSU = 2'd2
  } e_functional_unit;

  // R-type style field layout of a decoded op
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } operation_specification;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       rs_id;
    operation_specification op;
  } issue_bus;

  typedef struct packed {
    e_functional_unit fu;
    logic             known;
  } fu_class_t;

  function automatic logic has_rs1(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_LOAD, OPC_STORE};
  endfunction

  function automatic logic has_rs2(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_BRANCH, OPC_STORE};
  endfunction

  function automatic logic has_rd(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD};
  endfunction

  // Unknown opcodes report known=0; fu then defaults to ALU and is unused.
  function automatic fu_class_t fu_of_opcode(input logic [6:0] opc);
    fu_class_t c;
    c.fu    = FU_ALU;
    c.known = 1'b1;
    case (opc)
      OPC_OP, OPC_OP_IMM:  c.fu = FU_ALU;
      OPC_BRANCH:          c.fu = FU_BU;
      OPC_LOAD, OPC_STORE: c.fu = FU_LSU;
      default:             c.known = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-side handshake, issue broadcast and CDB bundle of the issue scheduler.
interface issue_scheduler_if;
  import issue_scheduler_pkg::*;

  logic                   in_valid;
  operation_specification in_op;
  logic                   in_ready;
  issue_bus               issue;
  logic                   issue_rs1_pending;
  logic [TAG_W-1:0]       issue_rs1_tag;
  logic                   issue_rs2_pending;
  logic [TAG_W-1:0]       issue_rs2_tag;
  logic                   illegal;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_rs_id;
  logic                   flush;

  modport master (
    output in_valid, in_op, cdb_valid, cdb_rs_id, flush,
    input  in_ready, issue, issue_rs1_pending, issue_rs1_tag,
           issue_rs2_pending, issue_rs2_tag, illegal
  );

  modport slave (
    input  in_valid, in_op, cdb_valid, cdb_rs_id, flush,
    output in_ready, issue, issue_rs1_pending, issue_rs1_tag,
           issue_rs2_pending, issue_rs2_tag, illegal
  );
endinterface

// File: rtl/issue_scheduler_reg_status_table.sv
// Register status table: per-register pending bit and producer tag.
// Two read ports with same-cycle CDB bypass; one set port that beats the CDB clear.
module reg_status_table
  import issue_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [1:0][REG_W-1:0]       rd_addr,
  output logic [1:0]                  rd_pend,
  output logic [1:0][TAG_W-1:0]       rd_tag,
  input  logic                        set_en,
  input  logic [REG_W-1:0]            set_addr,
  input  logic [TAG_W-1:0]            set_tag,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag
);

  logic [NUM_REGS-1:0]            pend;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag;

  // Lookup with bypass: a producer completing this cycle no longer counts as pending.
  always_comb begin
    rd_pend = '0;
    rd_tag  = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_addr[p] != '0 && pend[rd_addr[p]] &&
          !(cdb_valid && cdb_tag == tag[rd_addr[p]])) begin
        rd_pend[p] = 1'b1;
        rd_tag[p]  = tag[rd_addr[p]];
      end
    end
  end

  // Status update: clear-all, then CDB retire, then set (last assignment wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      tag  <= '0;
    end else if (clear) begin
      pend <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cdb_valid && pend[r] && tag[r] == cdb_tag) pend[r] <= 1'b0;
        if (set_en && r != 0 && set_addr == REG_W'(r)) begin
          pend[r] <= 1'b1;
          tag[r]  <= set_tag;
        end
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: classifies decoded ops, allocates RS slots, attaches source
// producer tags and drives a registered issue broadcast. CDB frees slots/tags.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  issue_scheduler_if.slave bus
);

  localparam int SLOT_W = (RS_PER_FU > 1) ? $clog2(RS_PER_FU) : 1;
  localparam int NSLOT  = 2**TAG_W;

  logic [NSLOT-1:0]     busy;
  fu_class_t            cls;
  logic [RS_PER_FU-1:0] unit_busy;
  logic [SLOT_W-1:0]    slot;
  logic                 free_any;
  logic [TAG_W-1:0]     alloc_tag;
  logic                 accept, issue_now, illegal_now;
  logic                 src1_used, src2_used;
  logic [1:0]           rst_pend;
  logic [1:0][TAG_W-1:0] rst_tag;
  logic                 set_en;

  issue_bus             issue_q;
  logic                 p1_q, p2_q, ill_q;
  logic [TAG_W-1:0]     t1_q, t2_q;

  assign cls       = fu_of_opcode(bus.in_op.opcode);
  assign unit_busy = busy[int'(cls.fu)*RS_PER_FU +: RS_PER_FU];

  // Lowest-index free slot of the target unit.
  always_comb begin
    slot     = '0;
    free_any = 1'b0;
    for (int s = RS_PER_FU-1; s >= 0; s--) begin
      if (!unit_busy[s]) begin
        slot     = SLOT_W'(s);
        free_any = 1'b1;
      end
    end
  end

  assign alloc_tag   = TAG_W'(int'(cls.fu)*RS_PER_FU + int'(slot));
  assign bus.in_ready = !bus.flush && (!cls.known || free_any);
  assign accept      = bus.in_valid && bus.in_ready;
  assign issue_now   = accept && cls.known;
  assign illegal_now = accept && !cls.known;
  assign src1_used   = has_rs1(bus.in_op.opcode);
  assign src2_used   = has_rs2(bus.in_op.opcode);
  assign set_en      = issue_now && has_rd(bus.in_op.opcode);

  reg_status_table u_rst (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .rd_addr   ({bus.in_op.rs2, bus.in_op.rs1}),
    .rd_pend   (rst_pend),
    .rd_tag    (rst_tag),
    .set_en    (set_en),
    .set_addr  (bus.in_op.rd),
    .set_tag   (alloc_tag),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_rs_id)
  );

  // Slot occupancy: CDB release first, allocation after (never the same slot).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (bus.flush) begin
      busy <= '0;
    end else begin
      if (bus.cdb_valid) busy[bus.cdb_rs_id] <= 1'b0;
      if (issue_now)     busy[alloc_tag]     <= 1'b1;
    end
  end

  // Registered issue broadcast; fields are zeroed whenever nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      t1_q    <= '0;
      t2_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      issue_q <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      t1_q    <= '0;
      t2_q    <= '0;
      ill_q   <= illegal_now;
      if (issue_now) begin
        issue_q.valid <= 1'b1;
        issue_q.rs_id <= alloc_tag;
        issue_q.op    <= bus.in_op;
        p1_q          <= src1_used && rst_pend[0];
        p2_q          <= src2_used && rst_pend[1];
        t1_q          <= (src1_used && rst_pend[0]) ? rst_tag[0] : '0;
        t2_q          <= (src2_used && rst_pend[1]) ? rst_tag[1] : '0;
      end
    end
  end

  assign bus.issue             = issue_q;
  assign bus.issue_rs1_pending = p1_q;
  assign bus.issue_rs1_tag     = t1_q;
  assign bus.issue_rs2_pending = p2_q;
  assign bus.issue_rs2_tag     = t2_q;
  assign bus.illegal           = ill_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, async-reset sequence and
// randomized traffic against a slot/scoreboard reference model.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scheduler_if bus();
  issue_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic vld; logic [6:0] opc; logic [4:0] rd, rs1, rs2;
    logic cdb; logic [2:0] cid; logic fl;
    logic e_rdy, e_vld; logic [2:0] e_id;
    logic e_p1; logic [2:0] e_t1; logic e_p2; logic [2:0] e_t2; logic e_ill;
  } vec_t;

  function automatic vec_t V(logic vld, logic [6:0] opc, int rd, int rs1, int rs2,
                             logic cdb, int cid, logic fl, logic rdy, logic ev, int id,
                             logic p1, int t1, logic p2, int t2, logic ill);
    vec_t v;
    v.vld = vld; v.opc = opc; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.cdb = cdb; v.cid = 3'(cid); v.fl = fl; v.e_rdy = rdy; v.e_vld = ev;
    v.e_id = 3'(id); v.e_p1 = p1; v.e_t1 = 3'(t1); v.e_p2 = p2; v.e_t2 = 3'(t2);
    v.e_ill = ill;
    return v;
  endfunction

  function automatic operation_specification mkop(logic [6:0] opc, logic [4:0] rd,
                                                  logic [4:0] rs1, logic [4:0] rs2);
    operation_specification o;
    o.funct7 = 7'h20; o.funct3 = 3'h1;
    o.opcode = opc; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    return o;
  endfunction

  task automatic drive(logic vld, operation_specification op, logic cdb, logic [2:0] cid, logic fl);
    bus.in_valid = vld; bus.in_op = op; bus.cdb_valid = cdb; bus.cdb_rs_id = cid; bus.flush = fl;
  endtask

  // ---------------- reference model ----------------
  // Occupancy per unit as bit lists, register scoreboard as plain arrays.
  bit m_busy[3][2];
  bit m_pend[32];
  int m_tag[32];

  task automatic model_reset();
    foreach (m_busy[u, s]) m_busy[u][s] = 0;
    foreach (m_pend[r]) begin m_pend[r] = 0; m_tag[r] = 0; end
  endtask

  // unit index, known, and which operand fields the instruction format uses
  task automatic classify(input logic [6:0] opc, output int unit, output bit known,
                          output bit u1, output bit u2, output bit ud);
    unit = 0; known = 1; u1 = 1; u2 = 0; ud = 0;
    case (opc)
      7'b0110011: begin unit = 0; u2 = 1; ud = 1; end
      7'b0010011: begin unit = 0; ud = 1; end
      7'b1100011: begin unit = 1; u2 = 1; end
      7'b0000011: begin unit = 2; ud = 1; end
      7'b0100011: begin unit = 2; u2 = 1; end
      default:    begin known = 0; u1 = 0; end
    endcase
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.vld, mkop(v.opc, v.rd, v.rs1, v.rs2), v.cdb, v.cid, v.fl);
    @(negedge clk);
    chk($sformatf("vec%0d in_ready", idx), 32'(bus.in_ready), 32'(v.e_rdy));
    @(posedge clk); #1;
    chk($sformatf("vec%0d valid", idx), 32'(bus.issue.valid), 32'(v.e_vld));
    chk($sformatf("vec%0d illegal", idx), 32'(bus.illegal), 32'(v.e_ill));
    if (v.e_vld) begin
      chk($sformatf("vec%0d rs_id", idx), 32'(bus.issue.rs_id), 32'(v.e_id));
      chk($sformatf("vec%0d p1", idx), 32'(bus.issue_rs1_pending), 32'(v.e_p1));
      chk($sformatf("vec%0d t1", idx), 32'(bus.issue_rs1_tag), 32'(v.e_t1));
      chk($sformatf("vec%0d p2", idx), 32'(bus.issue_rs2_pending), 32'(v.e_p2));
      chk($sformatf("vec%0d t2", idx), 32'(bus.issue_rs2_tag), 32'(v.e_t2));
      chk($sformatf("vec%0d op", idx), 32'(bus.issue.op), 32'(mkop(v.opc, v.rd, v.rs1, v.rs2)));
    end
  endtask

  vec_t vt[14];
  logic [6:0] opc_pool[6];

  initial begin
    vt[0]  = V(1, OPC_OP,     5, 1, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[1]  = V(1, OPC_OP,     6, 5, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    vt[2]  = V(1, OPC_OP_IMM, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = V(1, OPC_OP_IMM, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = V(1, OPC_OP_IMM, 7, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[5]  = V(1, OPC_LOAD,   8, 7, 6, 0, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0);
    vt[6]  = V(1, OPC_STORE,  9, 7, 6, 1, 0, 0, 1, 1, 5, 0, 0, 1, 1, 0);
    vt[7]  = V(1, OPC_BRANCH,10, 9, 8, 0, 0, 0, 1, 1, 2, 0, 0, 1, 4, 0);
    vt[8]  = V(1, OPC_OP,     0,10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[9]  = V(1, 7'h7f,      0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vt[10] = V(0, OPC_OP,     3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[11] = V(1, OPC_BRANCH, 0, 8, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[12] = V(1, OPC_OP,    12, 6, 8, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[13] = V(1, 7'h7f,      0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    opc_pool[0] = OPC_OP; opc_pool[1] = OPC_OP_IMM; opc_pool[2] = OPC_BRANCH;
    opc_pool[3] = OPC_LOAD; opc_pool[4] = OPC_STORE; opc_pool[5] = 7'h7f;

    // reset state
    drive(1, mkop(OPC_OP, 1, 2, 3), 0, 0, 0);
    #13;
    chk("reset valid", 32'(bus.issue.valid), 0);
    chk("reset issue", 32'(bus.issue), 0);
    chk("reset illegal", 32'(bus.illegal), 0);
    chk("reset pend", {bus.issue_rs1_pending, bus.issue_rs2_pending}, 0);
    chk("reset tags", {bus.issue_rs1_tag, bus.issue_rs2_tag}, 0);
    drive(0, mkop(OPC_OP, 1, 2, 3), 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) run_vec(vt[i], i);

    // async reset mid-stream
    drive(1, mkop(OPC_LOAD, 3, 0, 0), 0, 0, 0);
    @(posedge clk); #1;
    chk("pre-rst valid", 32'(bus.issue.valid), 1);
    drive(0, mkop(OPC_LOAD, 3, 0, 0), 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", 32'(bus.issue.valid), 0);
    chk("async rst issue", 32'(bus.issue), 0);
    @(negedge clk); rst = 1'b0;
    drive(1, mkop(OPC_OP, 4, 12, 0), 0, 0, 0);
    #1;
    chk("post-rst ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("post-rst rs_id", 32'(bus.issue.rs_id), 0);
    chk("post-rst p1", 32'(bus.issue_rs1_pending), 0);
    drive(0, mkop(OPC_OP, 0, 0, 0), 0, 0, 1);
    @(posedge clk); #1;
    model_reset();

    // randomized traffic vs. model
    for (int c = 0; c < 3000; c++) begin
      logic vld, cdb, fl;
      logic [2:0] cid;
      operation_specification op;
      int unit, slot, t, nbusy;
      bit known, u1, u2, ud, erdy, acc;
      bit ep1, ep2;
      int et1, et2;
      int cand[$];

      vld = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 99) < 3);
      op  = mkop(opc_pool[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      op.funct7 = 7'($urandom); op.funct3 = 3'($urandom);
      if (op.opcode == 7'h7f && $urandom_range(0, 1) == 1) op.opcode = 7'($urandom);
      for (int u = 0; u < 3; u++) for (int s = 0; s < 2; s++) if (m_busy[u][s]) cand.push_back(u*2 + s);
      cdb = ($urandom_range(0, 9) < 4);
      if (cand.size() > 0 && $urandom_range(0, 4) != 0) cid = 3'(cand[$urandom_range(0, cand.size()-1)]);
      else cid = 3'($urandom_range(0, 7));
      drive(vld, op, cdb, cid, fl);

      classify(op.opcode, unit, known, u1, u2, ud);
      slot = -1; nbusy = 0;
      for (int s = 1; s >= 0; s--) if (!m_busy[unit][s]) slot = s; else nbusy++;
      erdy = !fl && (!known || nbusy < 2);
      t = unit*2 + slot;
      acc = vld && erdy;
      ep1 = u1 && op.rs1 != 0 && m_pend[op.rs1] && !(cdb && int'(cid) == m_tag[op.rs1]);
      ep2 = u2 && op.rs2 != 0 && m_pend[op.rs2] && !(cdb && int'(cid) == m_tag[op.rs2]);
      et1 = ep1 ? m_tag[op.rs1] : 0;
      et2 = ep2 ? m_tag[op.rs2] : 0;

      @(negedge clk);
      chk("rnd in_ready", 32'(bus.in_ready), 32'(erdy));

      if (fl) model_reset();
      else begin
        if (cdb) begin
          if (cid < 6) m_busy[cid/2][cid%2] = 0;
          foreach (m_pend[r]) if (m_pend[r] && m_tag[r] == int'(cid)) m_pend[r] = 0;
        end
        if (acc && known) begin
          m_busy[unit][slot] = 1;
          if (ud && op.rd != 0) begin m_pend[op.rd] = 1; m_tag[op.rd] = t; end
        end
      end

      @(posedge clk); #1;
      chk("rnd valid", 32'(bus.issue.valid), 32'(acc && known));
      chk("rnd illegal", 32'(bus.illegal), 32'(acc && !known));
      if (acc && known) begin
        chk("rnd rs_id", 32'(bus.issue.rs_id), 32'(t));
        chk("rnd op", 32'(bus.issue.op), 32'(op));
        chk("rnd p1", 32'(bus.issue_rs1_pending), 32'(ep1));
        chk("rnd t1", 32'(bus.issue_rs1_tag), 32'(et1));
        chk("rnd p2", 32'(bus.issue_rs2_pending), 32'(ep2));
        chk("rnd t2", 32'(bus.issue_rs2_tag), 32'(et2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
